sokoban_move_sched: RTL and testbench

- Sits between the raw direction keys and the Sokoban move/map-update engine.
- Captures key presses once per video frame and queues them in a small FIFO.
- Issues at most one move per frame to the engine over a req/ack handshake, and owns the game-state sequence (initial, start, gaming, win).
- Also keeps the accepted-move counter used by the score/HUD overlay.

---
 rtl/sokoban_move_sched.sv | 170 +++++++++++++++++
 tb/tb_sokoban_move_sched.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sokoban_move_sched.sv
// Frame-paced move scheduler: samples direction keys once per VGA frame, queues them,
// and hands one move at a time to the map-update engine over a req/ack handshake.
module sokoban_move_sched #(
    parameter int QDEPTH        = 4,
    parameter int REPEAT_FRAMES = 8,
    parameter int ACK_TIMEOUT   = 64,
    parameter int CNT_W         = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vs,
    input  logic [3:0]       key,
    input  logic             win,
    input  logic             move_ack,
    input  logic             move_ok,
    output logic             move_req,
    output logic [1:0]       move_dir,
    output logic [1:0]       game_state,
    output logic [CNT_W-1:0] move_count,
    output logic             overflow,
    output logic             timeout_err
);
    localparam int PW = $clog2(QDEPTH);
    localparam int HW = $clog2(REPEAT_FRAMES + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [PW:0]   FULL_CNT   = QDEPTH[PW:0];
    localparam logic [HW-1:0] HOLD_LAST  = HW'(REPEAT_FRAMES - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_INIT   = 2'b00,
        S_START  = 2'b01,
        S_GAMING = 2'b10,
        S_WIN    = 2'b11
    } state_t;

    state_t        state, state_next;
    logic          vs_meta, vs_sync, vs_prev, frame_tick;
    logic [1:0]    fifo_mem [QDEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   fifo_cnt;
    logic          fifo_full, fifo_empty;
    logic [3:0]    prev_key;
    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] req_timer;
    logic          key_valid;
    logic [1:0]    key_dir;
    logic          capture, enter_win, key_event, do_push, do_pop;

    // vs comes from another clock domain; the tick fires on the synchronised rising edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vs_meta <= 1'b0;
            vs_sync <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            vs_meta <= vs;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
        end
    end

    assign frame_tick = vs_sync & ~vs_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_INIT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (frame_tick) begin
            case (state)
                S_INIT:   state_next = S_START;
                S_START:  state_next = S_GAMING;
                S_GAMING: if (win && !move_req) state_next = S_WIN;
                default:  state_next = state;
            endcase
        end
    end

    assign game_state = state;

    always_comb begin
        key_valid = 1'b1;
        key_dir   = 2'd0;
        case (key)
            4'b0001: key_dir = 2'd0;
            4'b0010: key_dir = 2'd1;
            4'b0100: key_dir = 2'd2;
            4'b1000: key_dir = 2'd3;
            default: key_valid = 1'b0;
        endcase
    end

    // Issue decisions look at the queue as it was before this tick's push
    assign fifo_full  = (fifo_cnt == FULL_CNT);
    assign fifo_empty = (fifo_cnt == '0);
    assign enter_win  = frame_tick && (state == S_GAMING) && win && !move_req;
    assign capture    = frame_tick && ((state == S_START) || ((state == S_GAMING) && !enter_win));
    assign do_pop     = frame_tick && (state == S_GAMING) && !enter_win && !fifo_empty && !move_req;
    assign key_event  = capture && key_valid && ((key != prev_key) || (hold_cnt == HOLD_LAST));
    assign do_push    = key_event && (!fifo_full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) fifo_mem[wr_ptr] <= key_dir;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (enter_win) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_key <= 4'b0000;
            hold_cnt <= '0;
            overflow <= 1'b0;
        end else if (capture) begin
            prev_key <= key;
            if (!key_valid || (key != prev_key) || (hold_cnt == HOLD_LAST))
                hold_cnt <= '0;
            else
                hold_cnt <= hold_cnt + HW'(1);
            if (key_event && fifo_full && !do_pop)
                overflow <= 1'b1;
        end
    end

    // An ack landing on the timeout cycle still counts as a completed move
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            move_req    <= 1'b0;
            move_dir    <= 2'd0;
            req_timer   <= '0;
            move_count  <= '0;
            timeout_err <= 1'b0;
        end else if (do_pop) begin
            move_req  <= 1'b1;
            move_dir  <= fifo_mem[rd_ptr];
            req_timer <= '0;
        end else if (move_req) begin
            if (move_ack) begin
                move_req <= 1'b0;
                if (move_ok && (move_count != '1))
                    move_count <= move_count + CNT_W'(1);
            end else if (req_timer == TIMER_LAST) begin
                move_req    <= 1'b0;
                timeout_err <= 1'b1;
            end else begin
                req_timer <= req_timer + TW'(1);
            end
        end
    end
endmodule

// File: tb/tb_sokoban_move_sched.sv
// Scoreboard bench for sokoban_move_sched: a frame-level reference model predicts each
// move request, and an independent monitor checks requests as the DUT raises them.
module tb_sokoban_move_sched;
    localparam int QDEPTH        = 4;
    localparam int REPEAT_FRAMES = 8;
    localparam int ACK_TIMEOUT   = 64;
    localparam int CNT_W         = 10;

    logic             clk      = 1'b0;
    logic             reset    = 1'b1;
    logic             vs       = 1'b0;
    logic [3:0]       key      = 4'b0000;
    logic             win      = 1'b0;
    logic             move_ack = 1'b0;
    logic             move_ok  = 1'b0;
    logic             move_req;
    logic [1:0]       move_dir;
    logic [1:0]       game_state;
    logic [CNT_W-1:0] move_count;
    logic             overflow;
    logic             timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [1:0] dir;
        int         dur;
    } exp_t;
    exp_t exp_q[$];

    bit eng_ack    = 1'b1;
    int eng_delay  = 0;
    bit eng_ok     = 1'b1;
    bit abort_next = 1'b0;

    int         m_state;
    logic [3:0] m_prev;
    int         m_hold;
    int         m_fifo[$];
    bit         m_req;
    int         m_clear;
    int         m_count;
    bit         m_ovf;
    bit         m_tmo;

    sokoban_move_sched #(
        .QDEPTH(QDEPTH), .REPEAT_FRAMES(REPEAT_FRAMES),
        .ACK_TIMEOUT(ACK_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .vs(vs), .key(key), .win(win),
        .move_ack(move_ack), .move_ok(move_ok), .move_req(move_req),
        .move_dir(move_dir), .game_state(game_state), .move_count(move_count),
        .overflow(overflow), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_state = 0;
        m_prev  = 4'b0000;
        m_hold  = 0;
        m_fifo.delete();
        m_req   = 1'b0;
        m_clear = 0;
        m_count = 0;
        m_ovf   = 1'b0;
        m_tmo   = 1'b0;
    endfunction

    function automatic void model_capture(input logic [3:0] k);
        bit enq = 1'b0;
        int dir = 0;
        if ($countones(k) != 1) begin
            m_hold = 0;
        end else if (k != m_prev) begin
            enq    = 1'b1;
            m_hold = 0;
        end else begin
            m_hold++;
            if (m_hold == REPEAT_FRAMES) begin
                enq    = 1'b1;
                m_hold = 0;
            end
        end
        m_prev = k;
        for (int i = 0; i < 4; i++) if (k[i]) dir = i;
        if (enq) begin
            if (m_fifo.size() >= QDEPTH) m_ovf = 1'b1;
            else                         m_fifo.push_back(dir);
        end
    endfunction

    function automatic void model_issue(input int t);
        exp_t e;
        e.dir   = 2'(m_fifo.pop_front());
        e.dur   = abort_next ? 0 : (eng_ack ? eng_delay + 1 : ACK_TIMEOUT);
        m_req   = 1'b1;
        m_clear = t + (eng_ack ? eng_delay + 1 : ACK_TIMEOUT);
        if (eng_ack && eng_ok && m_count < (1 << CNT_W) - 1) m_count++;
        if (!eng_ack) m_tmo = 1'b1;
        exp_q.push_back(e);
    endfunction

    // t is the clock edge at which the DUT acts on this frame's tick
    function automatic void model_tick(input int t, input logic [3:0] k, input logic w);
        bit busy;
        busy = m_req && (t <= m_clear);
        case (m_state)
            0: m_state = 1;
            1: begin
                model_capture(k);
                m_state = 2;
            end
            2: begin
                if (w && !busy) begin
                    m_state = 3;
                    m_fifo.delete();
                end else begin
                    if (!busy && m_fifo.size() > 0) model_issue(t);
                    model_capture(k);
                end
            end
            default: ;
        endcase
    endfunction

    task automatic applyStimulus(input logic [3:0] k, input logic w, input int len);
        int old_state;
        key = k;
        win = w;
        vs  = 1'b1;
        old_state = m_state;
        model_tick(cyc + 3, k, w);
        repeat (2) @(negedge clk);
        checkOutput("state_before_tick", game_state, old_state);
        @(negedge clk);
        checkOutput("state_at_tick", game_state, m_state);
        @(negedge clk);
        vs = 1'b0;
        repeat (len - 4) @(negedge clk);
    endtask

    task automatic checkStatus(input string tag);
        checkOutput({tag, "_req_idle"}, move_req, 0);
        checkOutput({tag, "_count"}, move_count, m_count);
        checkOutput({tag, "_overflow"}, overflow, m_ovf);
        checkOutput({tag, "_timeout"}, timeout_err, m_tmo);
    endtask

    initial begin : engine
        bit prev_req = 1'b0;
        int d;
        bit ok;
        forever begin
            @(negedge clk);
            if (move_req && !prev_req && eng_ack) begin
                d  = eng_delay;
                ok = eng_ok;
                repeat (d) @(negedge clk);
                move_ok  = ok;
                move_ack = 1'b1;
                @(negedge clk);
                move_ack = 1'b0;
                move_ok  = 1'b0;
            end
            prev_req = move_req;
        end
    end

    initial begin : monitor
        bit         in_req      = 1'b0;
        bit         have        = 1'b0;
        bit         dir_changed = 1'b0;
        int         dur         = 0;
        logic [1:0] dir0        = 2'd0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                in_req = 1'b0;
            end else if (move_req && !in_req) begin
                in_req      = 1'b1;
                dur         = 1;
                dir0        = move_dir;
                dir_changed = 1'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    have = 1'b0;
                    $display("[TB] FAIL unexpected_req: move_req rose with no predicted move, dir=%0d", move_dir);
                end else begin
                    e    = exp_q.pop_front();
                    have = 1'b1;
                    checkOutput("move_dir", move_dir, e.dir);
                end
            end else if (move_req) begin
                dur++;
                if (move_dir !== dir0) dir_changed = 1'b1;
            end else if (in_req) begin
                in_req = 1'b0;
                if (have && e.dur != 0) checkOutput("req_cycles", dur, e.dur);
                checkOutput("dir_stable", dir_changed, 0);
            end
        end
    end

    initial begin : stimulus
        logic [3:0] key_tab [8];
        logic [3:0] k = 4'b0000;
        int         len;
        key_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0011, 4'b1111, 4'b0110};

        model_reset();
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_req", move_req, 0);
        checkOutput("rst_dir", move_dir, 0);
        checkOutput("rst_state", game_state, 0);
        checkStatus("rst");
        reset = 1'b1;
        @(negedge clk);

        repeat (3) applyStimulus(4'b0000, 1'b0, 40);
        checkStatus("bringup");

        eng_ack = 1'b1; eng_delay = 4; eng_ok = 1'b1;
        applyStimulus(4'b0100, 1'b0, 40);
        applyStimulus(4'b0000, 1'b0, 40);
        applyStimulus(4'b0000, 1'b0, 40);
        checkStatus("single_move");

        eng_delay = 0;
        repeat (17) applyStimulus(4'b0001, 1'b0, 30);
        repeat (2) applyStimulus(4'b0000, 1'b0, 40);
        repeat (2) applyStimulus(4'b0011, 1'b0, 40);
        checkStatus("auto_repeat");

        eng_ack = 1'b0;
        for (int i = 0; i < 8; i++) applyStimulus(key_tab[i % 4], 1'b0, 20);
        repeat (5) applyStimulus(4'b0000, 1'b0, 100);
        checkStatus("overflow_timeout");

        for (int i = 0; i < 40; i++) begin
            eng_ack   = ($urandom_range(0, 3) != 0);
            eng_delay = $urandom_range(0, 10);
            eng_ok    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) k = key_tab[$urandom_range(0, 7)];
            len = ($urandom_range(0, 1) == 0) ? $urandom_range(20, 50) : $urandom_range(80, 110);
            applyStimulus(k, 1'b0, len);
        end
        eng_ack = 1'b1; eng_delay = 2;
        repeat (5) applyStimulus(4'b0000, 1'b0, 100);
        checkStatus("random");

        eng_ok = 1'b0;
        applyStimulus(4'b1000, 1'b0, 40);
        applyStimulus(4'b0000, 1'b0, 40);
        checkStatus("blocked_move");
        eng_ok = 1'b1;
        applyStimulus(4'b0100, 1'b0, 40);
        applyStimulus(4'b0010, 1'b0, 40);
        applyStimulus(4'b0001, 1'b1, 40);
        applyStimulus(4'b1000, 1'b0, 40);
        applyStimulus(4'b0100, 1'b0, 40);
        applyStimulus(4'b0000, 1'b0, 100);
        checkStatus("win");
        checkOutput("win_terminal", game_state, 3);

        reset = 1'b0;
        #1;
        checkOutput("rst_from_win_state", game_state, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        eng_ack = 1'b0;
        repeat (2) applyStimulus(4'b0000, 1'b0, 40);
        applyStimulus(4'b0001, 1'b0, 40);
        abort_next = 1'b1;
        applyStimulus(4'b0000, 1'b0, 10);
        checkOutput("req_before_reset", move_req, 1);
        reset = 1'b0;
        #1;
        checkOutput("async_rst_req", move_req, 0);
        checkOutput("async_rst_count", move_count, 0);
        checkOutput("async_rst_state", game_state, 0);
        model_reset();
        abort_next = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        repeat (3) applyStimulus(4'b0000, 1'b0, 40);
        checkStatus("restart");
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
